// File: rtl/log2_eval_sched.sv
// Two-requester scheduler evaluating piecewise-quadratic log2 on one shared ROM and multiplier; LOG2_ROUND_EN enables round-half-up with saturation.
// Latency: 4+ROM_LAT cycles from acceptance edge to z_valid; one operation in flight at a time.
// Backpressure: z_ready low holds OUT (z/z_id stable); no request is acknowledged while busy.
module log2_eval_sched #(
    parameter int K_SHIFT = 0,
    parameter int ROM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [22:0] X0,
    output logic        ack0,
    input  logic        req1,
    input  logic [22:0] X1,
    output logic        ack1,
    output logic        tbl_rd,
    output logic [5:0]  tbl_idx,
    input  logic [13:0] tbl_a,
    input  logic [37:0] tbl_b,
    input  logic [59:0] tbl_c,
    output logic        z_valid,
    input  logic        z_ready,
    output logic [22:0] z,
    output logic        z_id,
    output logic        busy
);

    localparam int AW = 64 + K_SHIFT;

    typedef enum logic [2:0] {IDLE, FETCH, SQ, AX, BX, SUM, OUT} state_t;

    state_t      state, state_nxt;
    logic        grant, grant_id;
    logic        last_id, id_q;
    logic [1:0]  lat_cnt;
    logic [16:0] x_q;
    logic [13:0] a_q;
    logic [37:0] b_q;
    logic [59:0] c_q;
    logic [33:0] p_q;
    logic [47:0] t_q;
    logic [54:0] s_q;
    logic [37:0] mul_a;
    logic [33:0] mul_b;
    logic [54:0] mul_p;
    logic [AW-1:0] acc;
    logic [22:0] z_nxt;
    logic        unused_acc;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_id  = 1'b0;
        case (state)
            IDLE: begin
                // On a tie, serve whoever was not granted last.
                if (req0 && req1) begin
                    grant    = 1'b1;
                    grant_id = ~last_id;
                end else if (req0) begin
                    grant    = 1'b1;
                    grant_id = 1'b0;
                end else if (req1) begin
                    grant    = 1'b1;
                    grant_id = 1'b1;
                end
                if (grant) state_nxt = FETCH;
            end
            FETCH:   if (lat_cnt == 2'(ROM_LAT - 1)) state_nxt = SQ;
            SQ:      state_nxt = AX;
            AX:      state_nxt = BX;
            BX:      state_nxt = SUM;
            SUM:     state_nxt = OUT;
            OUT:     if (z_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            SQ: begin
                mul_a = {21'd0, x_q};
                mul_b = {17'd0, x_q};
            end
            AX: begin
                mul_a = {24'd0, a_q};
                mul_b = p_q >> K_SHIFT;
            end
            BX: begin
                mul_a = b_q;
                mul_b = {17'd0, x_q};
            end
            default: ;
        endcase
    end

    // Every product used here fits in 55 bits, so the upper product bits are never formed.
    assign mul_p = 55'(mul_a) * 55'(mul_b);

    // t is shifted back up so the only precision loss is the truncation of x*x.
    assign acc = (AW'(s_q) << K_SHIFT) - (AW'(t_q) << K_SHIFT) + (AW'(c_q) << K_SHIFT);
    assign unused_acc = ^acc;

`ifdef LOG2_ROUND_EN
    logic [23:0] z_rnd;
    assign z_rnd = {1'b0, acc[37+K_SHIFT +: 23]} + {23'd0, acc[36+K_SHIFT]};
    assign z_nxt = z_rnd[23] ? 23'h7FFFFF : z_rnd[22:0];
`else
    assign z_nxt = acc[37+K_SHIFT +: 23];
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_id <= 1'b1;
            id_q    <= 1'b0;
            lat_cnt <= '0;
            x_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            p_q     <= '0;
            t_q     <= '0;
            s_q     <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            tbl_rd  <= 1'b0;
            tbl_idx <= '0;
            z_valid <= 1'b0;
            z       <= '0;
            z_id    <= 1'b0;
        end else begin
            state  <= state_nxt;
            ack0   <= grant && !grant_id;
            ack1   <= grant && grant_id;
            tbl_rd <= grant;
            if (grant) begin
                x_q     <= grant_id ? X1[16:0] : X0[16:0];
                tbl_idx <= grant_id ? X1[22:17] : X0[22:17];
                id_q    <= grant_id;
                last_id <= grant_id;
                lat_cnt <= '0;
            end
            case (state)
                FETCH: lat_cnt <= lat_cnt + 2'd1;
                SQ: begin
                    a_q <= tbl_a;
                    b_q <= tbl_b;
                    c_q <= tbl_c;
                    p_q <= mul_p[33:0];
                end
                AX:  t_q <= mul_p[47:0];
                BX:  s_q <= mul_p;
                SUM: begin
                    z       <= z_nxt;
                    z_id    <= id_q;
                    z_valid <= 1'b1;
                end
                OUT: if (z_ready) z_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
